// File: rtl/cpu_exec_stage_if.sv
// Bus bundle between the decode/execute stage and its environment
// (program memory, register file, switches/handshake and the output port).
interface cpu_exec_stage_if #(
  parameter int INSTR_WIDTH    = 16,
  parameter int REG_ADDR_WIDTH = 2,
  parameter int BUS_WIDTH      = 8
);
  logic [INSTR_WIDTH-1:0]    instr;
  logic [BUS_WIDTH-1:0]      rd_data_a;
  logic [BUS_WIDTH-1:0]      rd_data_b;
  logic [BUS_WIDTH-1:0]      in_port;
  logic                      ready_in;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_a;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_b;
  logic                      pc_en;
  logic                      we;
  logic [REG_ADDR_WIDTH-1:0] wr_addr;
  logic [BUS_WIDTH-1:0]      wr_data;
  logic [BUS_WIDTH-1:0]      out_port;

  // Execute-stage side
  modport master (
    input  instr, rd_data_a, rd_data_b, in_port, ready_in,
    output rd_addr_a, rd_addr_b, pc_en, we, wr_addr, wr_data, out_port
  );

  // Environment side (program memory, register file, I/O)
  modport slave (
    output instr, rd_data_a, rd_data_b, in_port, ready_in,
    input  rd_addr_a, rd_addr_b, pc_en, we, wr_addr, wr_data, out_port
  );
endinterface

// File: rtl/cpu_exec_stage.sv
// Decode/execute stage of the small 16-bit-instruction CPU.
// Decodes the current instruction, generates the PC enable (WAIT stalls),
// captures operands/control in one pipeline register with write-back
// forwarding, and computes the ALU result one cycle later.
module cpu_exec_stage #(
  parameter int INSTR_WIDTH    = 16,
  parameter int OPCODE_WIDTH   = 3,
  parameter int REG_ADDR_WIDTH = 2,
  parameter int BUS_WIDTH      = 8
) (
  input  logic             clk,
  input  logic             reset,
  cpu_exec_stage_if.master bus
);

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_NOP  = 3'b000,
    OP_ADD  = 3'b001,
    OP_LDI  = 3'b010,
    OP_LDSW = 3'b011,
    OP_WAIT = 3'b100,
    OP_MOV  = 3'b101,
    OP_OUT  = 3'b110,
    OP_NOP2 = 3'b111
  } opcode_e;

  // Instruction fields
  logic [INSTR_WIDTH-1:0]    ir;
  opcode_e                   opcode;
  logic [REG_ADDR_WIDTH-1:0] dest;
  logic [REG_ADDR_WIDTH-1:0] src_a;
  logic [REG_ADDR_WIDTH-1:0] src_b;
  logic [BUS_WIDTH-1:0]      imm;
  logic [1:0]                wait_mode;
  logic                      unused_msb;

  // Decode flags
  logic f_add;
  logic f_imm;
  logic f_load;
  logic f_wait;
  logic f_wr;

  // Input sampling
  logic [BUS_WIDTH-1:0] sw_q;
  logic                 rdy_q;
  logic                 pattern;
  logic                 cmp;

  // Pipeline register
  logic [BUS_WIDTH-1:0]      p_imm;
  logic                      p_f_imm;
  logic                      p_f_add;
  logic                      wr_sel;
  logic                      we_q;
  logic [REG_ADDR_WIDTH-1:0] wr_addr_q;
  logic [BUS_WIDTH-1:0]      op_a;
  logic [BUS_WIDTH-1:0]      op_b;

  // Operand selection and results
  logic [BUS_WIDTH-1:0] op_a_d;
  logic [BUS_WIDTH-1:0] op_b_d;
  logic [BUS_WIDTH-1:0] alu_res;
  logic [BUS_WIDTH-1:0] wr_data_i;

  assign ir         = bus.instr;
  assign opcode     = opcode_e'(ir[14:12]);
  assign dest       = ir[11:10];
  assign src_a      = ir[9:8];
  assign src_b      = ir[7:6];
  assign imm        = ir[7:0];
  assign wait_mode  = ir[1:0];
  assign unused_msb = ir[15];

  assign bus.rd_addr_a = src_a;
  assign bus.rd_addr_b = src_b;

  // Opcode decode into datapath control flags
  always_comb begin
    f_add  = 1'b0;
    f_imm  = 1'b0;
    f_load = 1'b0;
    f_wait = 1'b0;
    f_wr   = 1'b0;
    case (opcode)
      OP_ADD: begin
        f_add = 1'b1;
        f_wr  = 1'b1;
      end
      OP_LDI: begin
        f_imm = 1'b1;
        f_wr  = 1'b1;
      end
      OP_LDSW: begin
        f_load = 1'b1;
        f_wr   = 1'b1;
      end
      OP_WAIT: f_wait = 1'b1;
      OP_MOV:  f_wr   = 1'b1;
      default: ;
    endcase
  end

  // Sample switches and ready level; rdy_q resets high so a ready already
  // high at reset release is not mistaken for a rising edge
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_q  <= '0;
      rdy_q <= 1'b1;
    end else begin
      sw_q  <= bus.in_port;
      rdy_q <= bus.ready_in;
    end
  end

  // WAIT stall: mode bit 1 picks edge vs level, bit 0 picks the polarity
  // that releases the stall
  always_comb begin
    pattern   = ~rdy_q & bus.ready_in;
    cmp       = wait_mode[1] ? pattern : bus.ready_in;
    bus.pc_en = ~(f_wait & (cmp ^ wait_mode[0]));
  end

  // Forward the write-back value when the previous instruction writes a
  // register the current instruction reads
  always_comb begin
    op_a_d = bus.rd_data_a;
    op_b_d = bus.rd_data_b;
    if (we_q && (wr_addr_q == src_a)) op_a_d = wr_data_i;
    if (we_q && (wr_addr_q == src_b)) op_b_d = wr_data_i;
  end

  // Pipeline register between decode and execute
  always_ff @(posedge clk) begin
    if (reset) begin
      p_imm     <= '0;
      p_f_imm   <= 1'b1;
      p_f_add   <= 1'b0;
      wr_sel    <= 1'b0;
      we_q      <= 1'b0;
      wr_addr_q <= '0;
      op_a      <= '0;
      op_b      <= '0;
    end else begin
      p_imm     <= imm;
      p_f_imm   <= f_imm;
      p_f_add   <= f_add;
      wr_sel    <= f_load;
      we_q      <= f_wr;
      wr_addr_q <= dest;
      op_a      <= op_a_d;
      op_b      <= op_b_d;
    end
  end

  // ALU: immediate has priority over add, otherwise pass operand A
  always_comb begin
    if (p_f_imm)      alu_res = p_imm;
    else if (p_f_add) alu_res = op_a + op_b;
    else              alu_res = op_a;
    wr_data_i = wr_sel ? sw_q : alu_res;
  end

  assign bus.out_port = alu_res;
  assign bus.wr_data  = wr_data_i;
  assign bus.we       = we_q;
  assign bus.wr_addr  = wr_addr_q;

endmodule

// File: tb/tb_cpu_exec_stage.sv
// Directed bench for cpu_exec_stage: a vector table applied in sequence
// (forwarding and WAIT edge detection depend on the preceding vectors),
// followed by hand-written reset sequences.
module tb_cpu_exec_stage;

  logic clk = 1'b0;
  logic reset;

  cpu_exec_stage_if #(.INSTR_WIDTH(16), .REG_ADDR_WIDTH(2), .BUS_WIDTH(8)) bus ();

  cpu_exec_stage #(
    .INSTR_WIDTH(16),
    .OPCODE_WIDTH(3),
    .REG_ADDR_WIDTH(2),
    .BUS_WIDTH(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  sw;
    logic        rdy;
    logic        pc_en;
    logic [1:0]  ra;
    logic [1:0]  rb;
    logic [7:0]  out;
    logic        we;
    logic [1:0]  wa;
    logic [7:0]  wd;
  } vec_t;

  localparam int NV = 17;
  vec_t vt [NV];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic vec_t mk(logic [15:0] instr, logic [7:0] a, logic [7:0] b,
                              logic [7:0] sw, logic rdy, logic pc_en,
                              logic [1:0] ra, logic [1:0] rb, logic [7:0] out,
                              logic we, logic [1:0] wa, logic [7:0] wd);
    vec_t v;
    v.instr = instr; v.a = a; v.b = b; v.sw = sw; v.rdy = rdy;
    v.pc_en = pc_en; v.ra = ra; v.rb = rb; v.out = out;
    v.we = we; v.wa = wa; v.wd = wd;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [7:0] act, logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(logic [15:0] instr, logic [7:0] a, logic [7:0] b,
                       logic [7:0] sw, logic rdy);
    bus.instr     = instr;
    bus.rd_data_a = a;
    bus.rd_data_b = b;
    bus.in_port   = sw;
    bus.ready_in  = rdy;
  endtask

  initial begin
    //       instr     a      b      sw     rdy  pc  ra rb  out    we wa wd
    vt[0]  = mk(16'h4003, 8'h11, 8'h00, 8'hFF, 1, 0, 0, 0, 8'h11, 0, 0, 8'h11); // WAIT edge, ready high since reset
    vt[1]  = mk(16'h242A, 8'h00, 8'h00, 8'h00, 1, 1, 0, 0, 8'h2A, 1, 1, 8'h2A); // LDI r1,0x2A
    vt[2]  = mk(16'h12C0, 8'hF0, 8'h20, 8'h00, 1, 1, 2, 3, 8'h10, 1, 0, 8'h10); // ADD wrap
    vt[3]  = mk(16'h1D80, 8'h03, 8'h04, 8'h00, 1, 1, 1, 2, 8'h07, 1, 3, 8'h07); // ADD 3+4
    vt[4]  = mk(16'h2405, 8'h00, 8'h00, 8'h00, 1, 1, 0, 0, 8'h05, 1, 1, 8'h05); // LDI r1,5
    vt[5]  = mk(16'h1940, 8'h00, 8'h00, 8'h00, 1, 1, 1, 1, 8'h0A, 1, 2, 8'h0A); // ADD r2=r1+r1 forwarded
    vt[6]  = mk(16'h3C00, 8'h77, 8'h00, 8'h5C, 1, 1, 0, 0, 8'h77, 1, 3, 8'h5C); // LDSW r3
    vt[7]  = mk(16'h5300, 8'h99, 8'h00, 8'h00, 1, 1, 3, 0, 8'h5C, 1, 0, 8'h5C); // MOV r0=r3 forwarded switches
    vt[8]  = mk(16'h6200, 8'h3C, 8'h00, 8'h00, 1, 1, 2, 0, 8'h3C, 0, 0, 8'h3C); // OUT r2
    vt[9]  = mk(16'h4001, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00); // WAIT level, not ready
    vt[10] = mk(16'h4001, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00);
    vt[11] = mk(16'h4001, 8'h00, 8'h00, 8'h00, 1, 1, 0, 0, 8'h00, 0, 0, 8'h00); // WAIT level, ready
    vt[12] = mk(16'h4003, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00); // WAIT edge, low
    vt[13] = mk(16'h4003, 8'h00, 8'h00, 8'h00, 1, 1, 0, 0, 8'h00, 0, 0, 8'h00); // rising edge
    vt[14] = mk(16'h4003, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00); // held high
    vt[15] = mk(16'h4003, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00);
    vt[16] = mk(16'h7000, 8'hAB, 8'h00, 8'h00, 0, 1, 0, 0, 8'hAB, 0, 0, 8'hAB); // NOP passes A

    // Reset with ready high and switches all ones
    reset = 1'b1;
    drive(16'h0000, 8'h00, 8'h00, 8'hFF, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", -1, bus.out_port, 8'h00);
    chk("rst_we", -1, {7'd0, bus.we}, 8'h00);
    chk("rst_wd", -1, bus.wr_data, 8'h00);
    chk("rst_wa", -1, {6'd0, bus.wr_addr}, 8'h00);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vt[i].instr, vt[i].a, vt[i].b, vt[i].sw, vt[i].rdy);
      #2;
      chk("pc_en", i, {7'd0, bus.pc_en}, {7'd0, vt[i].pc_en});
      chk("rd_addr_a", i, {6'd0, bus.rd_addr_a}, {6'd0, vt[i].ra});
      chk("rd_addr_b", i, {6'd0, bus.rd_addr_b}, {6'd0, vt[i].rb});
      @(posedge clk);
      #1;
      chk("out_port", i, bus.out_port, vt[i].out);
      chk("we", i, {7'd0, bus.we}, {7'd0, vt[i].we});
      chk("wr_addr", i, {6'd0, bus.wr_addr}, {6'd0, vt[i].wa});
      chk("wr_data", i, bus.wr_data, vt[i].wd);
    end

    // LDI r2,0x33 writes normally
    drive(16'h2833, 8'h00, 8'h00, 8'h00, 1'b1);
    @(posedge clk);
    #1;
    chk("seq_ldi_out", 100, bus.out_port, 8'h33);
    chk("seq_ldi_we", 100, {7'd0, bus.we}, 8'h01);
    chk("seq_ldi_wa", 100, {6'd0, bus.wr_addr}, 8'h02);

    // ADD presented while reset asserts: its write must be cancelled
    reset = 1'b1;
    drive(16'h1000, 8'h01, 8'h02, 8'h44, 1'b1);
    @(posedge clk);
    #1;
    chk("seq_rst_we", 101, {7'd0, bus.we}, 8'h00);
    chk("seq_rst_out", 101, bus.out_port, 8'h00);
    chk("seq_rst_wd", 101, bus.wr_data, 8'h00);

    // After reset with ready already high, an edge WAIT must stall
    reset = 1'b0;
    drive(16'h4003, 8'h00, 8'h00, 8'h00, 1'b1);
    #2;
    chk("seq_wait_noedge", 102, {7'd0, bus.pc_en}, 8'h00);
    @(posedge clk);
    #1;
    chk("seq_wait_hold", 102, {7'd0, bus.pc_en}, 8'h00);

    // LDSW right after release picks up the switches of its own cycle
    drive(16'h3C00, 8'h12, 8'h00, 8'hC3, 1'b1);
    @(posedge clk);
    #1;
    chk("seq_ldsw_wd", 103, bus.wr_data, 8'hC3);
    chk("seq_ldsw_out", 103, bus.out_port, 8'h12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
